flght_seq: RTL and testbench

- Top-level flight sequencer that drives flght_cntrl.
- Spins the motors up, requests and supervises inertial calibration, then ramps thrust from zero to the slider value before handing thrust over to the pilot.
- Sits between cmd_cfg (commands), the inertial interface (calibration handshake) and flght_cntrl/ESC interface (inertial_cal, thrst, motor enable).

---
 rtl/flght_seq.sv | 140 ++++++++++++++
 tb/tb_flght_seq.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/flght_seq.sv
// Flight sequencer: spin-up, supervised inertial calibration, thrust ramp, then pilot thrust.
// Latency: every output is registered and updates on the clock edge after the input that causes it.
// Backpressure: none; motors_off aborts to IDLE at once and vld paces the ramp.
module flght_seq #(
  parameter logic [19:0] SPIN_CYC  = 20'd1000000,
  parameter logic [23:0] CAL_TMO   = 24'd5000000,
  parameter logic [8:0]  RAMP_STEP = 9'd4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cal_req,
  input  logic       motors_off,
  input  logic       cal_done,
  input  logic       vld,
  input  logic [8:0] thrst_cmd,
  output logic       inertial_cal,
  output logic       strt_cal,
  output logic [8:0] thrst,
  output logic       motors_en,
  output logic       seq_busy,
  output logic       cal_err
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SPIN = 3'd1,
    CAL  = 3'd2,
    RAMP = 3'd3,
    FLY  = 3'd4
  } state_t;

  // Terminal counts; the counter stops at these and never runs past them.
  localparam logic [23:0] SPIN_LAST = {4'd0, SPIN_CYC} - 24'd1;
  localparam logic [23:0] CAL_LAST  = CAL_TMO - 24'd1;

  state_t      state;
  logic [23:0] cnt;
  logic [9:0]  ramp_sum;

  // One bit of headroom so the ramp never wraps past 511.
  assign ramp_sum = {1'b0, thrst} + {1'b0, RAMP_STEP};

  // Sequencer state, cycle counter and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      inertial_cal <= 1'b0;
      strt_cal     <= 1'b0;
      thrst        <= '0;
      motors_en    <= 1'b0;
      seq_busy     <= 1'b0;
      cal_err      <= 1'b0;
    end else begin
      strt_cal <= 1'b0;
      if (motors_off) begin
        // Abort from anywhere; cal_err is left as is so a timeout stays visible.
        state        <= IDLE;
        cnt          <= '0;
        thrst        <= '0;
        motors_en    <= 1'b0;
        inertial_cal <= 1'b0;
        seq_busy     <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            motors_en    <= 1'b0;
            inertial_cal <= 1'b0;
            thrst        <= '0;
            seq_busy     <= 1'b0;
            if (cal_req) begin
              state        <= SPIN;
              cnt          <= '0;
              cal_err      <= 1'b0;
              motors_en    <= 1'b1;
              inertial_cal <= 1'b1;
              seq_busy     <= 1'b1;
            end
          end
          SPIN: begin
            // cal_done is meaningless before calibration has been requested.
            if (cnt == SPIN_LAST) begin
              state    <= CAL;
              cnt      <= '0;
              strt_cal <= 1'b1;
            end else begin
              cnt <= cnt + 24'd1;
            end
          end
          CAL: begin
            // A completion arriving on the timeout cycle still counts as success.
            if (cal_done) begin
              state        <= RAMP;
              cnt          <= '0;
              inertial_cal <= 1'b0;
            end else if (cnt == CAL_LAST) begin
              state        <= IDLE;
              cnt          <= '0;
              cal_err      <= 1'b1;
              motors_en    <= 1'b0;
              inertial_cal <= 1'b0;
              seq_busy     <= 1'b0;
            end else begin
              cnt <= cnt + 24'd1;
            end
          end
          RAMP: begin
            // Step toward the slider on each reading; a slider below the current
            // thrust is also caught here and resolves in a single step down.
            if (vld) begin
              if (ramp_sum >= {1'b0, thrst_cmd}) begin
                thrst    <= thrst_cmd;
                state    <= FLY;
                seq_busy <= 1'b0;
              end else begin
                thrst <= ramp_sum[8:0];
              end
            end
          end
          FLY: begin
            if (cal_req) begin
              state        <= SPIN;
              cnt          <= '0;
              thrst        <= '0;
              inertial_cal <= 1'b1;
              seq_busy     <= 1'b1;
            end else begin
              thrst <= thrst_cmd;
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_flght_seq.sv
// Bench for flght_seq: directed walk through the flight sequence, then randomized traffic.
// Expected outputs come from a phase/elapsed-time model of the sequencing rules.
// Outputs are checked 1 time unit after each rising clock edge.
module tb_flght_seq;

  localparam int SPIN_N = 8;
  localparam int TMO_N  = 32;
  localparam int STEP_N = 4;

  localparam int PH_IDLE = 0;
  localparam int PH_SPIN = 1;
  localparam int PH_CAL  = 2;
  localparam int PH_RAMP = 3;
  localparam int PH_FLY  = 4;

  logic       clk;
  logic       rst;
  logic       cal_req;
  logic       motors_off;
  logic       cal_done;
  logic       vld;
  logic [8:0] thrst_cmd;
  logic       inertial_cal;
  logic       strt_cal;
  logic [8:0] thrst;
  logic       motors_en;
  logic       seq_busy;
  logic       cal_err;

  int checks = 0;
  int errors = 0;

  // Reference model: current phase, cycles spent in it, and observable values.
  int ph      = PH_IDLE;
  int elapsed = 0;
  int m_thrst = 0;
  bit m_err   = 1'b0;
  bit m_strt  = 1'b0;

  flght_seq #(
    .SPIN_CYC (20'd8),
    .CAL_TMO  (24'd32),
    .RAMP_STEP(9'd4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cal_req     (cal_req),
    .motors_off  (motors_off),
    .cal_done    (cal_done),
    .vld         (vld),
    .thrst_cmd   (thrst_cmd),
    .inertial_cal(inertial_cal),
    .strt_cal    (strt_cal),
    .thrst       (thrst),
    .motors_en   (motors_en),
    .seq_busy    (seq_busy),
    .cal_err     (cal_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock using the inputs the DUT sampled on that edge.
  task automatic model_step();
    m_strt = 1'b0;
    if (rst) begin
      ph = PH_IDLE; elapsed = 0; m_thrst = 0; m_err = 1'b0;
    end else if (motors_off) begin
      ph = PH_IDLE; m_thrst = 0;
    end else if (ph == PH_IDLE) begin
      if (cal_req) begin ph = PH_SPIN; elapsed = 0; m_err = 1'b0; end
    end else if (ph == PH_SPIN) begin
      elapsed++;
      if (elapsed == SPIN_N) begin ph = PH_CAL; elapsed = 0; m_strt = 1'b1; end
    end else if (ph == PH_CAL) begin
      elapsed++;
      if (cal_done) ph = PH_RAMP;
      else if (elapsed == TMO_N) begin ph = PH_IDLE; m_err = 1'b1; end
    end else if (ph == PH_RAMP) begin
      if (vld) begin
        if (m_thrst + STEP_N >= int'(thrst_cmd)) begin m_thrst = int'(thrst_cmd); ph = PH_FLY; end
        else m_thrst = m_thrst + STEP_N;
      end
    end else begin
      if (cal_req) begin ph = PH_SPIN; elapsed = 0; m_thrst = 0; end
      else m_thrst = int'(thrst_cmd);
    end
  endtask

  // One clock: update the model, then compare every output against it.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("motors_en", {8'd0, motors_en}, {8'd0, ph != PH_IDLE});
    chk("inertial_cal", {8'd0, inertial_cal}, {8'd0, (ph == PH_SPIN) || (ph == PH_CAL)});
    chk("seq_busy", {8'd0, seq_busy}, {8'd0, (ph == PH_SPIN) || (ph == PH_CAL) || (ph == PH_RAMP)});
    chk("strt_cal", {8'd0, strt_cal}, {8'd0, m_strt});
    chk("cal_err", {8'd0, cal_err}, {8'd0, m_err});
    chk("thrst", thrst, m_thrst[8:0]);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int strt_seen;
    rst = 1'b1; cal_req = 1'b1; motors_off = 1'b0; cal_done = 1'b0; vld = 1'b0; thrst_cmd = 9'd10;

    // Reset held with cal_req active: everything stays at zero.
    ticks(2);
    chk("rst_motors_en", {8'd0, motors_en}, 9'd0);
    chk("rst_thrst", thrst, 9'd0);
    rst = 1'b0; cal_req = 1'b0;
    ticks(3);
    chk("idle_busy", {8'd0, seq_busy}, 9'd0);

    // Nominal sequence.
    cal_req = 1'b1; tick(); cal_req = 1'b0;
    chk("nom_motors_en", {8'd0, motors_en}, 9'd1);
    chk("nom_inertial", {8'd0, inertial_cal}, 9'd1);
    strt_seen = 0;
    for (int i = 0; i < SPIN_N; i++) begin
      tick();
      if (strt_cal === 1'b1) strt_seen++;
    end
    chk("nom_strt_once", strt_seen[8:0], 9'd1);
    chk("nom_strt_at8", {8'd0, strt_cal}, 9'd1);
    cal_done = 1'b1; tick(); cal_done = 1'b0;
    chk("nom_cal_off", {8'd0, inertial_cal}, 9'd0);
    chk("nom_strt_drop", {8'd0, strt_cal}, 9'd0);
    vld = 1'b1;
    tick(); chk("nom_ramp1", thrst, 9'd4);
    tick(); chk("nom_ramp2", thrst, 9'd8);
    tick(); chk("nom_ramp3", thrst, 9'd10);
    chk("nom_busy_fall", {8'd0, seq_busy}, 9'd0);
    vld = 1'b0; thrst_cmd = 9'd200;
    tick(); chk("fly_follow", thrst, 9'd200);

    // Recalibration from FLY, with cal_req ignored during RAMP.
    thrst_cmd = 9'd300;
    tick(); chk("fly_300", thrst, 9'd300);
    cal_req = 1'b1; tick(); cal_req = 1'b0;
    chk("recal_thrst0", thrst, 9'd0);
    chk("recal_inertial", {8'd0, inertial_cal}, 9'd1);
    ticks(SPIN_N);
    cal_done = 1'b1; tick(); cal_done = 1'b0;
    cal_req = 1'b1; tick(); cal_req = 1'b0;
    chk("ramp_creq_busy", {8'd0, seq_busy}, 9'd1);
    chk("ramp_creq_ic", {8'd0, inertial_cal}, 9'd0);
    vld = 1'b1;
    for (int i = 0; i < 100 && seq_busy === 1'b1; i++) tick();
    vld = 1'b0;
    chk("recal_fly_thrst", thrst, 9'd300);
    chk("recal_fly_busy", {8'd0, seq_busy}, 9'd0);

    // Calibration timeout, then a new cal_req clears the error.
    motors_off = 1'b1; tick(); motors_off = 1'b0;
    cal_req = 1'b1; tick(); cal_req = 1'b0;
    ticks(SPIN_N + TMO_N);
    chk("tmo_err", {8'd0, cal_err}, 9'd1);
    chk("tmo_motors", {8'd0, motors_en}, 9'd0);
    cal_req = 1'b1; tick(); cal_req = 1'b0;
    chk("tmo_err_clr", {8'd0, cal_err}, 9'd0);

    // cal_done on the last CAL cycle wins over the timeout.
    ticks(SPIN_N + TMO_N - 1);
    cal_done = 1'b1; tick(); cal_done = 1'b0;
    chk("race_busy", {8'd0, seq_busy}, 9'd1);
    chk("race_err", {8'd0, cal_err}, 9'd0);
    chk("race_ic", {8'd0, inertial_cal}, 9'd0);
    thrst_cmd = 9'd0; vld = 1'b1; tick(); vld = 1'b0;
    chk("zero_cmd_thrst", thrst, 9'd0);
    chk("zero_cmd_fly", {8'd0, seq_busy}, 9'd0);

    // cal_done in SPIN ignored, motors_off mid-CAL, later cal_done ignored.
    cal_req = 1'b1; tick(); cal_req = 1'b0;
    cal_done = 1'b1; tick(); cal_done = 1'b0;
    ticks(SPIN_N - 1 + 5);
    chk("spin_done_ign", {8'd0, inertial_cal}, 9'd1);
    motors_off = 1'b1; tick(); motors_off = 1'b0;
    chk("abort_motors", {8'd0, motors_en}, 9'd0);
    cal_done = 1'b1; tick(); cal_done = 1'b0;
    chk("late_done_ign", {8'd0, seq_busy}, 9'd0);

    // Full-scale ramp reaches 511 without wrapping.
    cal_req = 1'b1; tick(); cal_req = 1'b0;
    ticks(SPIN_N);
    cal_done = 1'b1; tick(); cal_done = 1'b0;
    thrst_cmd = 9'd511; vld = 1'b1;
    ticks(127);
    chk("max_127", thrst, 9'd508);
    tick();
    vld = 1'b0;
    chk("max_128", thrst, 9'd511);
    chk("max_fly", {8'd0, seq_busy}, 9'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rst        = ($urandom_range(0, 299) == 0);
      motors_off = ($urandom_range(0, 39) == 0);
      cal_req    = ($urandom_range(0, 9) == 0);
      cal_done   = ($urandom_range(0, 5) == 0);
      vld        = ($urandom_range(0, 1) == 0);
      thrst_cmd  = 9'($urandom_range(0, 511));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
